// File: rtl/axis_pkt_arbiter_pkg.sv
// axis_pkt_arbiter_pkg: shared data_io stream constants, FSM encodings and header layout
package axis_pkt_arbiter_pkg;
    localparam int DATA_W      = 32;
    localparam int KEEP_W      = DATA_W / 8;
    localparam int HDR_CNT_LSB = 0;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'b00;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_beat_t;
    function automatic logic [DATA_W-1:0] hdr_field(input logic [DATA_W-1:0] d);
        return d >> HDR_CNT_LSB;
    endfunction
endpackage

// File: rtl/axis_pkt_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin pick; last = 1 means requester 1 was served last
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb grant = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: two-source round-robin AXI-Stream packet arbiter with header-count length checking
module axis_pkt_arbiter
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    input  logic              S0_AXIS_TVALID,
    input  logic [DATA_W-1:0] S0_AXIS_TDATA,
    input  logic [KEEP_W-1:0] S0_AXIS_TKEEP,
    input  logic              S0_AXIS_TLAST,
    output logic              S0_AXIS_TREADY,
    input  logic              S1_AXIS_TVALID,
    input  logic [DATA_W-1:0] S1_AXIS_TDATA,
    input  logic [KEEP_W-1:0] S1_AXIS_TKEEP,
    input  logic              S1_AXIS_TLAST,
    output logic              S1_AXIS_TREADY,
    output logic              M_AXIS_TVALID,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic [KEEP_W-1:0] M_AXIS_TKEEP,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic [1:0]        grant,
    output logic              err_short,
    output logic              err_long,
    input  logic              err_clr
);
    logic [1:0]       state_q, state_d, grant_q, grant_d, arb_gnt;
    logic             last_q, last_d, hdr_q, hdr_d;
    logic             err_short_q, err_short_d, err_long_q, err_long_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hdr_cnt;
    axis_beat_t       src;
    logic             src_valid, src_ready, src_fire, cnt_end, xfer_st, drain_st, idle_st;
    logic             set_short, set_long;

    rr_arb2 u_arb (
        .req   ({S1_AXIS_TVALID, S0_AXIS_TVALID}),
        .last  (last_q),
        .grant (arb_gnt)
    );

    always_comb begin
        src       = grant_q[1] ? {S1_AXIS_TDATA, S1_AXIS_TKEEP, S1_AXIS_TLAST}
                               : {S0_AXIS_TDATA, S0_AXIS_TKEEP, S0_AXIS_TLAST};
        src_valid = grant_q[1] ? S1_AXIS_TVALID : S0_AXIS_TVALID;
        xfer_st   = state_q == ST_XFER;
        drain_st  = state_q == ST_DRAIN;
        idle_st   = !xfer_st && !drain_st;
        hdr_cnt   = CNT_W'(hdr_field(src.data));
        cnt_end   = hdr_q ? hdr_cnt == '0 : cnt_q == CNT_W'(1);
        src_ready = xfer_st ? M_AXIS_TREADY : drain_st;
        src_fire  = src_valid && src_ready;
    end

    assign S0_AXIS_TREADY = grant_q[0] & src_ready;
    assign S1_AXIS_TREADY = grant_q[1] & src_ready;
    assign M_AXIS_TVALID  = xfer_st & src_valid;
    assign M_AXIS_TDATA   = src.data;
    assign M_AXIS_TKEEP   = src.keep;
    assign M_AXIS_TLAST   = xfer_st & (cnt_end | src.last);
    assign grant          = grant_q;
    assign err_short      = err_short_q;
    assign err_long       = err_long_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hdr_d     = hdr_q;
        cnt_d     = cnt_q;
        set_short = 1'b0;
        set_long  = 1'b0;
        if (idle_st) begin
            state_d = ST_IDLE;
            grant_d = GNT_NONE;
            if (|arb_gnt) begin
                state_d = ST_XFER;
                grant_d = arb_gnt;
                last_d  = arb_gnt[1];
                hdr_d   = 1'b1;
            end
        end else if (xfer_st && src_fire) begin
            hdr_d = 1'b0;
            cnt_d = hdr_q ? hdr_cnt : cnt_q - CNT_W'(1);
            if (src.last) begin
                state_d   = ST_IDLE;
                grant_d   = GNT_NONE;
                set_short = !cnt_end;
            end else if (cnt_end) begin
                // count satisfied but the source keeps going: swallow the rest of its packet
                state_d  = ST_DRAIN;
                set_long = 1'b1;
            end
        end else if (drain_st && src_fire && src.last) begin
            state_d = ST_IDLE;
            grant_d = GNT_NONE;
        end
        err_short_d = set_short | (err_short_q & ~err_clr);
        err_long_d  = set_long  | (err_long_q  & ~err_clr);
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_NONE;
            last_q      <= 1'b1;
            hdr_q       <= 1'b0;
            cnt_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed packets with a beat scoreboard for axis_pkt_arbiter
module tb_axis_pkt_arbiter;
    typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
    typedef struct packed {logic [31:0] d; logic [3:0] k; logic l; logic [1:0] g; int gap;} exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        s0_v = 0, s0_l = 0, s1_v = 0, s1_l = 0, m_r = 0, err_clr = 0;
    logic [31:0] s0_d = 0, s1_d = 0;
    logic [3:0]  s0_k = 0, s1_k = 0;
    logic        s0_r, s1_r, m_v, m_l, err_short, err_long;
    logic [31:0] m_d;
    logic [3:0]  m_k;
    logic [1:0]  grant;

    beat_t s0_q[$], s1_q[$];
    exp_t  exp_q[$];
    bit    rdy_q[$];
    int    vectors = 0, miscompares = 0, cyc = 0, last_out = 0, tag = 0;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.CNT_W(16)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S0_AXIS_TVALID(s0_v), .S0_AXIS_TDATA(s0_d), .S0_AXIS_TKEEP(s0_k), .S0_AXIS_TLAST(s0_l), .S0_AXIS_TREADY(s0_r),
        .S1_AXIS_TVALID(s1_v), .S1_AXIS_TDATA(s1_d), .S1_AXIS_TKEEP(s1_k), .S1_AXIS_TLAST(s1_l), .S1_AXIS_TREADY(s1_r),
        .M_AXIS_TVALID(m_v), .M_AXIS_TDATA(m_d), .M_AXIS_TKEEP(m_k), .M_AXIS_TLAST(m_l), .M_AXIS_TREADY(m_r),
        .grant(grant), .err_short(err_short), .err_long(err_long), .err_clr(err_clr)
    );

    task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag_s, obs, expv);
        end
    endtask

    // queue one source packet and the beats the arbiter must forward for it
    task automatic pkt(input int src, input int n, input int beats, input bit slast, input int gap0, input bit tight);
        beat_t b;
        exp_t  e;
        tag++;
        for (int i = 0; i < beats; i++) begin
            b.d = (i == 0) ? {8'(tag), 8'h5A, 16'(n)} : {8'(tag), 8'(src), 16'(i)};
            b.k = 4'(i * 5 + 3);
            b.l = slast && (i == beats - 1);
            if (src == 0) s0_q.push_back(b); else s1_q.push_back(b);
            if (i <= n) begin
                e.d   = b.d;
                e.k   = b.k;
                e.l   = (i == 0 && n == 0) || (i > 0 && i == n) || b.l;
                e.g   = (src == 0) ? 2'b01 : 2'b10;
                e.gap = (i == 0) ? gap0 : (tight ? 1 : 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        bit   f0, f1;
        exp_t e;
        s0_v = s0_q.size() != 0;
        {s0_d, s0_k, s0_l} = s0_v ? s0_q[0] : '0;
        s1_v = s1_q.size() != 0;
        {s1_d, s1_k, s1_l} = s1_v ? s1_q[0] : '0;
        m_r = rdy_q.size() != 0 ? rdy_q.pop_front() : 1'b1;
        #4;
        if (m_v) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'(exp_q.size()), 32'd1);
            else if (m_r) begin
                e = exp_q.pop_front();
                chk("tdata", m_d, e.d);
                chk("tkeep", 32'(m_k), 32'(e.k));
                chk("tlast", 32'(m_l), 32'(e.l));
                chk("grant", 32'(grant), 32'(e.g));
                if (e.gap != 0) chk("beat_gap", 32'(cyc - last_out), 32'(e.gap));
                last_out = cyc;
            end else chk("stall_tdata", m_d, exp_q[0].d);
            chk("tready_mirror", 32'(grant[1] ? s1_r : s0_r), 32'(m_r));
        end
        f0 = s0_v & s0_r;
        f1 = s1_v & s1_r;
        @(posedge clk);
        cyc++;
        if (f0) void'(s0_q.pop_front());
        if (f1) void'(s1_q.pop_front());
        @(negedge clk);
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((s0_q.size() != 0 || s1_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("run_timeout", 32'(s0_q.size() + s1_q.size()), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        s0_q.delete();
        s1_q.delete();
        exp_q.delete();
        {s0_v, s0_l, s1_v, s1_l} = '0;
        m_r = 1'b1;
    endtask

    initial begin
        s0_v = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s0_tready", 32'(s0_r), 32'd0);
        chk("rst_m_tvalid", 32'(m_v), 32'd0);
        chk("rst_errs", 32'({err_short, err_long}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_s0_tready", 32'(s0_r), 32'd0);
        chk("post_rst_m_tvalid", 32'(m_v), 32'd0);
        s0_v = 1'b0;
        @(negedge clk);

        // both sources contend right after reset: S0 first, one idle cycle, then S1
        pkt(0, 1, 2, 1, 0, 1);
        pkt(1, 1, 2, 1, 2, 1);
        run(40);
        chk("rr_errs", 32'({err_short, err_long}), 32'd0);

        pkt(0, 3, 4, 1, 0, 1);
        run(40);
        chk("n3_errs", 32'({err_short, err_long}), 32'd0);

        // short packet with err_clr held: the set in the same cycle must win
        err_clr = 1'b1;
        pkt(1, 4, 3, 1, 0, 1);
        run(40);
        err_clr = 1'b0;
        #1;
        chk("short_err_short", 32'(err_short), 32'd1);
        chk("short_err_long", 32'(err_long), 32'd0);
        chk("short_idle_grant", 32'(grant), 32'd0);
        @(negedge clk);
        chk("short_sticky", 32'(err_short), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("short_cleared", 32'(err_short), 32'd0);
        @(negedge clk);

        pkt(0, 1, 4, 1, 0, 1);
        run(40);
        #1;
        chk("long_err_long", 32'(err_long), 32'd1);
        chk("long_err_short", 32'(err_short), 32'd0);
        chk("long_idle_grant", 32'(grant), 32'd0);
        chk("long_idle_tready", 32'(s0_r), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("long_cleared", 32'(err_long), 32'd0);
        @(negedge clk);

        rdy_q = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        pkt(0, 2, 3, 1, 0, 0);
        run(40);
        rdy_q.delete();

        // maximum header count must load without wrapping; source ends it early
        pkt(1, 65535, 3, 1, 0, 1);
        run(40);
        #1;
        chk("maxn_err_short", 32'(err_short), 32'd1);
        chk("maxn_err_long", 32'(err_long), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // abandon a packet mid-payload with an asynchronous reset
        pkt(0, 3, 2, 0, 0, 1);
        run(40);
        chk("mid_grant_held", 32'(grant), 32'd1);
        s0_v = 1'b1;
        s0_d = 32'h1234_5678;
        #1;
        chk("mid_pre_rst_tready", 32'(s0_r), 32'd1);
        chk("mid_pre_rst_tvalid", 32'(m_v), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tready", 32'(s0_r), 32'd0);
        chk("mid_rst_tvalid", 32'(m_v), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_tlast", 32'(m_l), 32'd0);
        s0_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pkt(0, 0, 1, 1, 0, 1);
        run(40);
        chk("n0_errs", 32'({err_short, err_long}), 32'd0);

        // N=0 header alone must carry TLAST; the extra source beat is drained
        pkt(1, 0, 2, 1, 0, 1);
        run(40);
        #1;
        chk("n0_long_err", 32'(err_long), 32'd1);
        chk("n0_long_idle", 32'(grant), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
